ws2812_in: RTL
==============

Name: ws2812_in

Overview:
- Receive-side counterpart of the WS2812 output path: decodes an incoming WS2812 serial stream into bytes.
- Measures each high pulse in clock cycles and classifies it as bit 0 or bit 1, MSB first.
- Assembles bytes, indexes them within a frame, and flags the latch gap as end of frame.
- Used for daisy-chain input and for loopback checking of the layer output path.

Parameters:
CNT_WIDTH, 16, width of the pulse/gap counter
BIT_THRESH, 44, high-pulse length in cycles at or above which a bit decodes as 1
HIGH_MAX, 120, high-pulse length in cycles at which the pulse is declared a fault
RESET_CNT, 4000, low-gap length in cycles that marks latch/end of frame (50 us at 80 MHz)
MIN_HIGH, 8, minimum valid high-pulse length in cycles (used only with the optional feature)
ADDR_WIDTH, 9, width of the byte index

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous, active-high reset
ws2812_data_in  input  1  asynchronous serial line
byte_vld_out  output  1  one-cycle strobe; byte_data_out and byte_idx_out valid
byte_data_out  output  8  decoded byte, first received bit in bit 7
byte_idx_out  output  ADDR_WIDTH  index of this byte within the current frame
frame_done_out  output  1  one-cycle strobe at latch gap after a frame carrying at least one bit
err_out  output  1  one-cycle strobe on a fault
busy_out  output  1  high while a frame is in progress

Behaviour:
- Reset is synchronous and active-high on rst_in, sampled on clk_in; it is the only clock.
- Reset values: every output 0; state SYNC; counter, bit_cnt and byte index 0; synchronizer flops 0.
- Input path: 2-flop synchronizer, then one edge register. Rise/fall are detected on the synchronized value against its registered copy.
- Latency: ws2812_data_in falling at the pin to byte_vld_out high is exactly 4 clk_in cycles. frame_done_out has the same pipeline offset relative to the gap count.
- SYNC:
  - Waits for a clean line. Counter counts synchronized-low cycles; any high clears it to 0.
  - When the count reaches RESET_CNT: go to LOW, clear index/bit_cnt. No frame_done_out.
- LOW:
  - On rise: go to HIGH with counter = 1.
  - Otherwise counter increments, saturating at RESET_CNT.
  - On reaching RESET_CNT with at least one bit received since frame start: pulse frame_done_out. If bit_cnt != 0, also pulse err_out in the same cycle and discard the partial byte.
  - In both cases, clear index and bit_cnt and stay in LOW.
- HIGH:
  - Counter increments each high cycle.
  - On fall: bit = (counter >= BIT_THRESH); shift it into the shift register; bit_cnt increments; go to LOW with counter = 1.
  - When bit_cnt wraps 7 to 0:
    - Pulse byte_vld_out with the byte and the current index.
    - Index then increments, wrapping modulo 2^ADDR_WIDTH with no flag.
  - When counter reaches HIGH_MAX before a fall: pulse err_out, discard the partial byte, go to SYNC with counter 0.
  - No frame_done_out for a frame aborted this way.
- busy_out = 1 in HIGH, and in LOW when at least one bit has been received since frame start.
- byte_data_out and byte_idx_out hold their last values between strobes.
- Simultaneous events:
  - rst_in overrides everything.
  - Reset mid-byte or mid-frame drops all partial data with no strobe.
- No back-pressure: the consumer must accept every byte_vld_out. Strobes are at least 8×(BIT_THRESH/2) cycles apart for legal streams.

Optional Feature:
WS2812_IN_GLITCH_FILTER_EN
- Defined: a high pulse shorter than MIN_HIGH cycles (fall seen with counter < MIN_HIGH) is discarded. No bit is shifted, bit_cnt is unchanged, and the block returns to LOW with counter = 1. A glitch never triggers err_out.
- Undefined: MIN_HIGH is ignored and every high pulse, including a 1-cycle one, decodes as a bit (0 if below BIT_THRESH).

Test Plan:
1. Reset held, line low; release and hold low 4000 cycles, then send 0xA5 (T1H = 56, T0H = 28, TL = 50 cycles) -> byte_vld_out once, data 0xA5, idx 0, 4 cycles after the last fall; busy_out 1.
2. Three bytes 0x12, 0x34, 0x56 followed by a 4000-cycle low gap -> strobes with idx 0, 1, 2; frame_done_out one cycle; err_out 0; busy_out 0; next frame restarts at idx 0.
3. Five bits then a 4000-cycle gap -> no byte_vld_out; frame_done_out and err_out pulse in the same cycle; next frame's first byte decodes correctly at idx 0.
4. High held 120 cycles mid-byte -> err_out pulse; no byte_vld_out; block ignores bits until a fresh 4000-cycle low; the following 0xFF decodes at idx 0.
5. Threshold boundaries: pulses of 43 and 44 cycles -> decode as 0 and 1. With WS2812_IN_GLITCH_FILTER_EN, a 3-cycle pulse inside byte 0x80 -> still 0x80. Without the macro, the same stream shifts in an extra 0 bit.
6. 512 bytes in one frame with ADDR_WIDTH = 9 -> idx 511 then 0 on byte 513; rst_in asserted mid-byte -> all outputs 0 next cycle, no strobes.

Source files
------------

// File: rtl/ws2812_in.sv
// rtl/ws2812_in.sv - WS2812 serial stream receiver that decodes pulses into indexed bytes
//
// Purpose:
//   Samples an asynchronous WS2812 line, measures every high pulse in clk_in
//   cycles and classifies it as a 0 or 1 bit (MSB first). Eight bits make a
//   byte, which is strobed out together with its index inside the frame. A low
//   gap of RESET_CNT cycles is the latch that ends a frame.
//
// Optional build macro:
//   WS2812_IN_GLITCH_FILTER_EN - high pulses shorter than MIN_HIGH cycles are
//   dropped instead of decoding as a 0 bit.
//
// Ports:
//   clk_in          system clock (only clock)
//   rst_in          synchronous, active-high reset
//   ws2812_data_in  asynchronous serial line
//   byte_vld_out    one-cycle strobe, byte_data_out/byte_idx_out valid
//   byte_data_out   decoded byte, first received bit in bit 7
//   byte_idx_out    index of the byte within the current frame
//   frame_done_out  one-cycle strobe at the latch gap of a non-empty frame
//   err_out         one-cycle strobe on a fault
//   busy_out        high while a frame is in progress

module ws2812_in #(
  parameter int CNT_WIDTH  = 16,
  parameter int BIT_THRESH = 44,
  parameter int HIGH_MAX   = 120,
  parameter int RESET_CNT  = 4000,
  parameter int MIN_HIGH   = 8,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  ws2812_data_in,
  output logic                  byte_vld_out,
  output logic [7:0]            byte_data_out,
  output logic [ADDR_WIDTH-1:0] byte_idx_out,
  output logic                  frame_done_out,
  output logic                  err_out,
  output logic                  busy_out
);

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LP_THRESH   = CNT_WIDTH'(BIT_THRESH);
  localparam logic [CNT_WIDTH-1:0] LP_HIGH_MAX = CNT_WIDTH'(HIGH_MAX);
  localparam logic [CNT_WIDTH-1:0] LP_RESET    = CNT_WIDTH'(RESET_CNT);
  localparam logic [CNT_WIDTH-1:0] LP_MIN_HIGH = CNT_WIDTH'(MIN_HIGH);

`ifdef WS2812_IN_GLITCH_FILTER_EN
  localparam logic LP_GLITCH_EN = 1'b1;
`else
  localparam logic LP_GLITCH_EN = 1'b0;
`endif

  // Input pipeline: two synchronizer flops, a registered copy of the
  // synchronized level, and registered edge flags. The FSM works on r_line,
  // r_rise and r_fall, which are mutually aligned.
  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_line;
  logic                  r_rise;
  logic                  r_fall;

  state_t                r_state;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [7:0]            r_shift;
  logic [2:0]            r_bit_cnt;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic                  r_any_bit;   // at least one bit decoded since frame start

  logic                  r_byte_vld;
  logic [7:0]            r_byte_data;
  logic [ADDR_WIDTH-1:0] r_byte_idx;
  logic                  r_frame_done;
  logic                  r_err;

  logic [CNT_WIDTH-1:0]  w_cnt_inc;
  logic                  w_bit;
  logic [7:0]            w_shift;
  logic                  w_glitch;

  assign w_cnt_inc = r_cnt + CNT_WIDTH'(1);
  assign w_bit     = (r_cnt >= LP_THRESH);
  assign w_shift   = {r_shift[6:0], w_bit};
  assign w_glitch  = LP_GLITCH_EN && (r_cnt < LP_MIN_HIGH);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_line       <= 1'b0;
      r_rise       <= 1'b0;
      r_fall       <= 1'b0;
      r_state      <= ST_SYNC;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_idx        <= '0;
      r_any_bit    <= 1'b0;
      r_byte_vld   <= 1'b0;
      r_byte_data  <= '0;
      r_byte_idx   <= '0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_sync1      <= ws2812_data_in;
      r_sync2      <= r_sync1;
      r_line       <= r_sync2;
      r_rise       <= r_sync2 & ~r_line;
      r_fall       <= ~r_sync2 & r_line;

      r_byte_vld   <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;

      case (r_state)
        // Wait for RESET_CNT consecutive low cycles before trusting the line.
        ST_SYNC: begin
          if (r_line) begin
            r_cnt <= '0;
          end else if (w_cnt_inc >= LP_RESET) begin
            // Enter LOW already saturated so no frame_done fires here.
            r_state   <= ST_LOW;
            r_cnt     <= LP_RESET;
            r_idx     <= '0;
            r_bit_cnt <= '0;
            r_any_bit <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        ST_LOW: begin
          if (r_rise) begin
            r_state <= ST_HIGH;
            r_cnt   <= CNT_WIDTH'(1);
          end else if (r_cnt < LP_RESET) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == LP_RESET) begin
              // Latch gap: close the frame; a partial byte is a fault.
              r_frame_done <= r_any_bit;
              r_err        <= r_any_bit && (r_bit_cnt != 3'd0);
              r_idx        <= '0;
              r_bit_cnt    <= '0;
              r_any_bit    <= 1'b0;
            end
          end
        end

        ST_HIGH: begin
          if (r_fall) begin
            r_state <= ST_LOW;
            r_cnt   <= CNT_WIDTH'(1);
            if (!w_glitch) begin
              r_shift   <= w_shift;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_any_bit <= 1'b1;
              if (r_bit_cnt == 3'd7) begin
                r_byte_vld  <= 1'b1;
                r_byte_data <= w_shift;
                r_byte_idx  <= r_idx;
                r_idx       <= r_idx + ADDR_WIDTH'(1);
              end
            end
          end else if (w_cnt_inc >= LP_HIGH_MAX) begin
            // Stuck-high line: abort the frame and resynchronize.
            r_err     <= 1'b1;
            r_state   <= ST_SYNC;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_any_bit <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        default: begin
          r_state <= ST_SYNC;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign byte_vld_out   = r_byte_vld;
  assign byte_data_out  = r_byte_data;
  assign byte_idx_out   = r_byte_idx;
  assign frame_done_out = r_frame_done;
  assign err_out        = r_err;
  assign busy_out       = (r_state == ST_HIGH) || ((r_state == ST_LOW) && r_any_bit);

endmodule
